coeff_read_fsm: RTL and testbench
=================================

# coeff_read_fsm

Read sequencer for the FIR coefficient SP-SRAM, sitting directly upstream of the RAM access multiplexer: it drives the `*_Fsm` chip-select, write-enable and address inputs of that mux. It walks coefficients 0..NUM_TAP-1 once per new input sample and delivers each coefficient with its index to the MAC datapath. It stands down whenever the Top-side coefficient update is active.

## Interface
- NUM_TAP, default 16: number of coefficients read per sample. Legal range 1..16.
- DATA_WIDTH, default 16: coefficient width in bits.

- iClk12M  input  1  system clock; all logic is on the rising edge.
- iRst  input  1  synchronous reset, active-high.
- iUpdateFlag  input  1  high while Top owns the SRAM; aborts or blocks sequencing.
- iEnSample  input  1  single-cycle start pulse, one per new input sample.
- iRdDt  input  DATA_WIDTH  SRAM read data, valid the cycle after its address cycle.
- oCsn_Fsm  output  1  SRAM chip select, active-low, registered.
- oWrn_Fsm  output  1  SRAM write enable, active-low; constant 1 (read only).
- oAddr_Fsm  output  4  SRAM address, registered.
- oCoeff  output  DATA_WIDTH  registered coefficient.
- oCoeffValid  output  1  oCoeff and oCoeffIdx are valid this cycle.
- oCoeffIdx  output  4  index of oCoeff.
- oLast  output  1  qualifies the valid for index NUM_TAP-1.
- oBusy  output  1  high in READ and DRAIN.
- oDone  output  1  one-cycle pulse after a complete sequence.
- oOverrun  output  1  sticky; set when a start is dropped because the block is busy. Cleared only by iRst.

## Operation
- States:
  - IDLE
  - READ: address counter rAddr runs 0..NUM_TAP-1.
  - DRAIN: 2 cycles.
  - DONE: 1 cycle.
- Reset (iRst=1 at an edge) forces IDLE and sets these outputs:
  - oCsn_Fsm=1, oWrn_Fsm=1, oAddr_Fsm=0, oCoeff=0, oCoeffIdx=0.
  - oCoeffValid=0, oLast=0, oBusy=0, oDone=0, oOverrun=0.
  - The valid/index pipeline is cleared.
  - Reset mid-sequence discards all in-flight reads; no oDone is issued.
- Start acceptance:
  - iEnSample=1 and iUpdateFlag=0 in IDLE or DONE: go to READ with rAddr=0.
  - iEnSample=1 in READ or DRAIN: ignored, and oOverrun is set.
  - iEnSample=1 while iUpdateFlag=1: ignored, and oOverrun is not set.
- READ:
  - oCsn_Fsm=0, oAddr_Fsm=rAddr, rAddr increments each cycle.
  - After the cycle with rAddr=NUM_TAP-1, go to DRAIN.
- Read-data pipeline:
  - Stage 1 carries the index alongside each issued address.
  - Stage 2 registers iRdDt into oCoeff together with the index and oLast = (idx==NUM_TAP-1).
- DRAIN: oCsn_Fsm=1. Stay 2 cycles so the last coefficient leaves the pipeline, then go to DONE.
- DONE: oDone=1, then IDLE, or READ if a start is accepted in this cycle.
- In IDLE, DRAIN and DONE: oCsn_Fsm=1 and oAddr_Fsm holds 0.
- Abort:
  - iUpdateFlag=1 at any edge in READ or DRAIN sends the block to IDLE on that edge.
  - Both pipeline stages are flushed: oCoeffValid=0 from the next cycle.
  - No oDone is issued, and the block does not resume.
- Index and address use 4 bits. NUM_TAP=16 ends at 15 with no wrap past it.

## Timing
- Start sampled at edge S:
  - Address k is driven during cycle S+1+k, for k = 0..NUM_TAP-1.
  - oCoeffValid for index k is high during cycle S+3+k.
  - oLast is high during cycle S+NUM_TAP+2.
  - oDone is high during cycle S+NUM_TAP+3.
- Read latency is 2 cycles from address to oCoeff.
- Minimum start-to-start spacing is NUM_TAP+3 cycles (the start falls in the DONE cycle).
- oBusy is high for cycles S+1 .. S+NUM_TAP+2.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Basic sequence, NUM_TAP=16:
  - Stimulus: SRAM preloaded with coeff[k]=0x0100+k; pulse iEnSample at S.
  - Response: oAddr_Fsm steps 0..15 over S+1..S+16 with oCsn_Fsm=0; oCoeff/oCoeffIdx pairs are 0x0100/0 .. 0x010F/15 over S+3..S+18; oLast at S+18; oDone at S+19; oWrn_Fsm stays 1 throughout.
- Abort on update:
  - Stimulus: iUpdateFlag=1 at the edge where address 3 would be driven.
  - Response: state is IDLE, oCsn_Fsm=1 from that cycle, at most the already-registered valid appears, and there is no oDone.
  - A later start with iUpdateFlag=0 runs a clean 16-read sequence.
- Overrun:
  - Stimulus: a second iEnSample at S+5.
  - Response: it is ignored, oOverrun=1 and stays 1, and the first sequence completes unchanged.
- Back-to-back:
  - Stimulus: iEnSample during the DONE cycle (S+19).
  - Response: address 0 is driven at S+20, with no gap and no overrun.
- NUM_TAP=1:
  - Response: a single read of address 0, with oCoeffValid and oLast together at S+3 and oDone at S+4.
- Reset mid-sequence:
  - Stimulus: iRst=1 at S+8.
  - Response: all outputs take their reset values on the next cycle, the pipeline is empty, no oDone is issued, and oOverrun is cleared.

Source files
------------

// File: rtl/coeff_read_fsm.sv
// Coefficient read sequencer: walks SRAM addresses 0..NUM_TAP-1 once per input sample
// and delivers each coefficient with its index to the MAC datapath.
module coeff_read_fsm #(
    parameter int NUM_TAP    = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  iClk12M,
    input  logic                  iRst,
    input  logic                  iUpdateFlag,
    input  logic                  iEnSample,
    input  logic [DATA_WIDTH-1:0] iRdDt,
    output logic                  oCsn_Fsm,
    output logic                  oWrn_Fsm,
    output logic [3:0]            oAddr_Fsm,
    output logic [DATA_WIDTH-1:0] oCoeff,
    output logic                  oCoeffValid,
    output logic [3:0]            oCoeffIdx,
    output logic                  oLast,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oOverrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_TAP - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_addr;
    logic [3:0]              w_addr_nxt;
    logic                    r_drain_cnt;
    logic                    w_drain_cnt_nxt;
    logic                    w_busy_st;
    logic                    w_start_ok;
    logic                    w_abort;
    logic                    w_issue;
    logic                    w_overrun_set;

    logic                    r_csn_p0;
    logic [3:0]              r_addr_p0;
    logic                    r_vld_p0;
    logic [3:0]              r_idx_p0;
    logic                    r_vld_p1;
    logic [3:0]              r_idx_p1;
    logic [DATA_WIDTH-1:0]   r_coeff_p2;
    logic                    r_vld_p2;
    logic [3:0]              r_idx_p2;
    logic                    r_last_p2;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_overrun;

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = 4'd0;
        w_drain_cnt_nxt = 1'b0;
        w_busy_st       = (r_state == READ) || (r_state == DRAIN);
        w_start_ok      = iEnSample && !iUpdateFlag;
        w_abort         = w_busy_st && iUpdateFlag;
        w_issue         = (r_state == READ) && !iUpdateFlag;
        w_overrun_set   = w_busy_st && iEnSample && !iUpdateFlag;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_state_nxt = READ;
            end
            READ: begin
                if (iUpdateFlag)              w_state_nxt = IDLE;
                else if (r_addr == LAST_IDX)  w_state_nxt = DRAIN;
                else                          w_addr_nxt  = r_addr + 4'd1;
            end
            DRAIN: begin
                if (iUpdateFlag)      w_state_nxt     = IDLE;
                else if (r_drain_cnt) w_state_nxt     = DONE;
                else                  w_drain_cnt_nxt = 1'b1;
            end
            DONE: begin
                w_state_nxt = w_start_ok ? READ : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            r_state     <= IDLE;
            r_addr      <= 4'd0;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            r_csn_p0   <= 1'b1;
            r_addr_p0  <= 4'd0;
            r_vld_p0   <= 1'b0;
            r_idx_p0   <= 4'd0;
            r_vld_p1   <= 1'b0;
            r_idx_p1   <= 4'd0;
            r_coeff_p2 <= '0;
            r_vld_p2   <= 1'b0;
            r_idx_p2   <= 4'd0;
            r_last_p2  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            // p0: SRAM address cycle, index travels with the address
            r_csn_p0  <= !w_issue;
            r_addr_p0 <= w_issue ? r_addr : 4'd0;
            r_vld_p0  <= w_issue;
            r_idx_p0  <= w_issue ? r_addr : 4'd0;
            // p1: aligned with SRAM read data; an abort flushes everything in flight
            r_vld_p1  <= r_vld_p0 && !w_abort;
            r_idx_p1  <= r_idx_p0;
            // p2: registered coefficient output
            r_vld_p2  <= r_vld_p1 && !w_abort;
            r_last_p2 <= r_vld_p1 && !w_abort && (r_idx_p1 == LAST_IDX);
            if (r_vld_p1 && !w_abort) begin
                r_coeff_p2 <= iRdDt;
                r_idx_p2   <= r_idx_p1;
            end
            r_busy    <= w_busy_st && !w_abort;
            r_done    <= (r_state == DONE);
            r_overrun <= r_overrun || w_overrun_set;
        end
    end

    assign oCsn_Fsm    = r_csn_p0;
    assign oWrn_Fsm    = 1'b1;
    assign oAddr_Fsm   = r_addr_p0;
    assign oCoeff      = r_coeff_p2;
    assign oCoeffValid = r_vld_p2;
    assign oCoeffIdx   = r_idx_p2;
    assign oLast       = r_last_p2;
    assign oBusy       = r_busy;
    assign oDone       = r_done;
    assign oOverrun    = r_overrun;

endmodule

// File: tb/tb_coeff_read_fsm.sv
// Scoreboard bench for coeff_read_fsm: a 16-tap instance and a 1-tap instance, each
// fed from a registered SRAM model preloaded with 0x0100+k.
module tb_coeff_read_fsm;

    typedef struct {
        logic [15:0] coeff;
        logic [3:0]  idx;
        logic        last;
        int          k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, upd, en, en1;
    logic [15:0] rd, rd1;
    logic        csn, wrn, cvld, last, busy, done, ovr;
    logic [3:0]  addr, cidx;
    logic [15:0] coeff;
    logic        csn1, wrn1, cvld1, last1, busy1, done1, ovr1;
    logic [3:0]  addr1, cidx1;
    logic [15:0] coeff1;
    logic [15:0] mem [16];
    exp_t        exp_q [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    coeff_read_fsm #(.NUM_TAP(16), .DATA_WIDTH(16)) u_dut (
        .iClk12M(clk), .iRst(rst), .iUpdateFlag(upd), .iEnSample(en), .iRdDt(rd),
        .oCsn_Fsm(csn), .oWrn_Fsm(wrn), .oAddr_Fsm(addr), .oCoeff(coeff),
        .oCoeffValid(cvld), .oCoeffIdx(cidx), .oLast(last), .oBusy(busy),
        .oDone(done), .oOverrun(ovr)
    );

    coeff_read_fsm #(.NUM_TAP(1), .DATA_WIDTH(16)) u_dut1 (
        .iClk12M(clk), .iRst(rst), .iUpdateFlag(upd), .iEnSample(en1), .iRdDt(rd1),
        .oCsn_Fsm(csn1), .oWrn_Fsm(wrn1), .oAddr_Fsm(addr1), .oCoeff(coeff1),
        .oCoeffValid(cvld1), .oCoeffIdx(cidx1), .oLast(last1), .oBusy(busy1),
        .oDone(done1), .oOverrun(ovr1)
    );

    always @(posedge clk) if (!csn)  rd  <= mem[addr];
    always @(posedge clk) if (!csn1) rd1 <= mem[addr1];

    task automatic push_seq(input int n, input int ntap, input int k0);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.coeff = 16'h0100 + 16'(i);
            e.idx   = 4'(i);
            e.last  = (i == ntap - 1);
            e.k     = k0 + i;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (csn !== 1'b1 || wrn !== 1'b1 || addr !== 4'd0) begin
            bad++; $display("FAIL reset_sram csn=%b wrn=%b addr=%0d want 1/1/0", csn, wrn, addr);
        end
        total++;
        if (coeff !== 16'd0 || cidx !== 4'd0 || cvld !== 1'b0 || last !== 1'b0) begin
            bad++; $display("FAIL reset_coeff coeff=%h idx=%0d vld=%b last=%b want 0", coeff, cidx, cvld, last);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0 || csn1 !== 1'b1 || cvld1 !== 1'b0) begin
            bad++; $display("FAIL reset_status busy=%b done=%b ovr=%b csn1=%b vld1=%b", busy, done, ovr, csn1, cvld1);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        @(negedge clk); en = 1'b1;
        push_seq(16, 16, 3);
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            if (k == 0) en = 1'b0;
            total++;
            if (csn !== ((k >= 1 && k <= 16) ? 1'b0 : 1'b1) ||
                addr !== ((k >= 1 && k <= 16) ? 4'(k - 1) : 4'd0)) begin
                bad++; $display("FAIL basic_addr k=%0d csn=%b addr=%0d", k, csn, addr);
            end
            total++;
            if (wrn !== 1'b1 || busy !== (k >= 1 && k <= 18) || done !== (k == 19)) begin
                bad++; $display("FAIL basic_status k=%0d wrn=%b busy=%b done=%b", k, wrn, busy, done);
            end
            if (cvld) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL basic_spurious k=%0d idx=%0d", k, cidx);
                end else begin
                    e = exp_q.pop_front();
                    if (coeff !== e.coeff || cidx !== e.idx || last !== e.last || k != e.k) begin
                        bad++; $display("FAIL basic_coeff k=%0d got %h/%0d/%b want %h/%0d/%b at k=%0d", k, coeff, cidx, last, e.coeff, e.idx, e.last, e.k);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].k == k) begin
                total++; bad++; $display("FAIL basic_missing k=%0d want idx=%0d", k, exp_q[0].idx);
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL basic_left got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk); en = 1'b1;
        push_seq(16, 16, 3);
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 0 || k == 19) en = 1'b0;
            if (k == 18) begin en = 1'b1; push_seq(16, 16, 22); end
            total++;
            if (csn !== ((k >= 1 && k <= 16) || (k >= 20 && k <= 35) ? 1'b0 : 1'b1) ||
                addr !== ((k >= 1 && k <= 16) ? 4'(k - 1) : (k >= 20 && k <= 35) ? 4'(k - 20) : 4'd0)) begin
                bad++; $display("FAIL b2b_addr k=%0d csn=%b addr=%0d", k, csn, addr);
            end
            total++;
            if (done !== (k == 19 || k == 38) || ovr !== 1'b0) begin
                bad++; $display("FAIL b2b_status k=%0d done=%b ovr=%b", k, done, ovr);
            end
            if (cvld) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_spurious k=%0d idx=%0d", k, cidx);
                end else begin
                    e = exp_q.pop_front();
                    if (coeff !== e.coeff || cidx !== e.idx || last !== e.last || k != e.k) begin
                        bad++; $display("FAIL b2b_coeff k=%0d got %h/%0d/%b want %h/%0d/%b at k=%0d", k, coeff, cidx, last, e.coeff, e.idx, e.last, e.k);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].k == k) begin
                total++; bad++; $display("FAIL b2b_missing k=%0d want idx=%0d", k, exp_q[0].idx);
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_abort();
        exp_t e;
        @(negedge clk); en = 1'b1;
        push_seq(1, 16, 3);
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (k == 0) en = 1'b0;
            if (k == 3) upd = 1'b1;
            if (k == 5) en = 1'b1;
            if (k == 6) begin en = 1'b0; upd = 1'b0; end
            if (k >= 4) begin
                total++;
                if (csn !== 1'b1 || addr !== 4'd0 || done !== 1'b0 || busy !== 1'b0 || ovr !== 1'b0) begin
                    bad++; $display("FAIL abort_idle k=%0d csn=%b addr=%0d done=%b busy=%b ovr=%b", k, csn, addr, done, busy, ovr);
                end
            end
            if (cvld) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL abort_spurious k=%0d idx=%0d", k, cidx);
                end else begin
                    e = exp_q.pop_front();
                    if (coeff !== e.coeff || cidx !== e.idx || k != e.k) begin
                        bad++; $display("FAIL abort_coeff k=%0d got %h/%0d want %h/%0d at k=%0d", k, coeff, cidx, e.coeff, e.idx, e.k);
                    end
                end
            end
        end
        exp_q.delete();
        // a clean sequence after the update has finished
        @(negedge clk); en = 1'b1;
        push_seq(16, 16, 3);
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            if (k == 0) en = 1'b0;
            total++;
            if (done !== (k == 19)) begin bad++; $display("FAIL abort_rerun_done k=%0d done=%b", k, done); end
            if (cvld) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL abort_rerun_spurious k=%0d idx=%0d", k, cidx);
                end else begin
                    e = exp_q.pop_front();
                    if (coeff !== e.coeff || cidx !== e.idx || last !== e.last || k != e.k) begin
                        bad++; $display("FAIL abort_rerun_coeff k=%0d got %h/%0d/%b want %h/%0d/%b", k, coeff, cidx, last, e.coeff, e.idx, e.last);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL abort_rerun_left got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_overrun();
        exp_t e;
        @(negedge clk); en = 1'b1;
        push_seq(16, 16, 3);
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            if (k == 0 || k == 5) en = 1'b0;
            if (k == 4) en = 1'b1;
            total++;
            if (ovr !== (k >= 5) || done !== (k == 19) ||
                addr !== ((k >= 1 && k <= 16) ? 4'(k - 1) : 4'd0)) begin
                bad++; $display("FAIL overrun_state k=%0d ovr=%b done=%b addr=%0d", k, ovr, done, addr);
            end
            if (cvld) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL overrun_spurious k=%0d idx=%0d", k, cidx);
                end else begin
                    e = exp_q.pop_front();
                    if (coeff !== e.coeff || cidx !== e.idx || last !== e.last || k != e.k) begin
                        bad++; $display("FAIL overrun_coeff k=%0d got %h/%0d/%b want %h/%0d/%b", k, coeff, cidx, last, e.coeff, e.idx, e.last);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL overrun_left got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(negedge clk); en = 1'b1;
        push_seq(5, 16, 3);
        for (int k = 0; k <= 25; k++) begin
            @(negedge clk);
            if (k == 0) en = 1'b0;
            if (k == 7) rst = 1'b1;
            if (k == 8) begin
                rst = 1'b0;
                total++;
                if (csn !== 1'b1 || wrn !== 1'b1 || addr !== 4'd0 || coeff !== 16'd0 || cidx !== 4'd0 ||
                    cvld !== 1'b0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0) begin
                    bad++; $display("FAIL rstmid_outputs csn=%b addr=%0d coeff=%h idx=%0d vld=%b busy=%b ovr=%b want reset values", csn, addr, coeff, cidx, cvld, busy, ovr);
                end
            end
            if (k > 8) begin
                total++;
                if (done !== 1'b0 || csn !== 1'b1) begin bad++; $display("FAIL rstmid_idle k=%0d done=%b csn=%b", k, done, csn); end
            end
            if (cvld) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rstmid_spurious k=%0d idx=%0d", k, cidx);
                end else begin
                    e = exp_q.pop_front();
                    if (coeff !== e.coeff || cidx !== e.idx || k != e.k) begin
                        bad++; $display("FAIL rstmid_coeff k=%0d got %h/%0d want %h/%0d", k, coeff, cidx, e.coeff, e.idx);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rstmid_left got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_ntap1();
        exp_t e;
        @(negedge clk); en1 = 1'b1;
        push_seq(1, 1, 3);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 0) en1 = 1'b0;
            total++;
            if (csn1 !== (k == 1 ? 1'b0 : 1'b1) || addr1 !== 4'd0 || done1 !== (k == 4) || busy1 !== (k >= 1 && k <= 3)) begin
                bad++; $display("FAIL ntap1_ctrl k=%0d csn=%b addr=%0d done=%b busy=%b", k, csn1, addr1, done1, busy1);
            end
            if (cvld1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL ntap1_spurious k=%0d idx=%0d", k, cidx1);
                end else begin
                    e = exp_q.pop_front();
                    if (coeff1 !== e.coeff || cidx1 !== e.idx || last1 !== e.last || k != e.k) begin
                        bad++; $display("FAIL ntap1_coeff k=%0d got %h/%0d/%b want %h/%0d/%b", k, coeff1, cidx1, last1, e.coeff, e.idx, e.last);
                    end
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL ntap1_left got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
        rst = 1'b1; upd = 1'b0; en = 1'b0; en1 = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_abort();
        test_overrun();
        test_reset_mid();
        test_ntap1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
